// File: rtl/vpifo_sched_pkg.sv
// Shared types and sizing helpers for the vPIFO pop scheduler.
// Contents: FSM state type, per-tree capacity function, default widths.
package vpifo_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   localparam int DEF_LEVEL    = 4;
   localparam int DEF_TREE_NUM = 4;

   // Element capacity of one virtual tree of the given depth.
   function automatic int cap(input int level);
      return 4 * ((4 ** level - 1) / 3);
   endfunction

   localparam int TID_W = $clog2(DEF_TREE_NUM);
   localparam int CNT_W = $clog2(cap(DEF_LEVEL) + 1);

endpackage

// File: rtl/vpifo_rr_pick.sv
// Rotating-priority picker: first set bit of i_mask at or after i_ptr,
// wrapping around. Purely combinational.
// Ports:
//   i_mask  - eligibility mask, one bit per tree
//   i_ptr   - starting index of the search
//   o_found - at least one mask bit set
//   o_idx   - index of the selected tree (0 when nothing found)
module vpifo_rr_pick
   import vpifo_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int TW = $clog2(N)
) (
   input  logic [N-1:0]  i_mask,
   input  logic [TW-1:0] i_ptr,
   output logic          o_found,
   output logic [TW-1:0] o_idx
);

   always_comb begin : p_pick
      logic [TW:0] w_pos;
      o_found = 1'b0;
      o_idx   = '0;
      w_pos   = '0;
      for (int i = 0; i < N; i++) begin
         w_pos = {1'b0, i_ptr} + (TW+1)'(i);
         if (w_pos >= (TW+1)'(N)) w_pos = w_pos - (TW+1)'(N);
         if (!o_found && i_mask[w_pos[TW-1:0]]) begin
            o_found = 1'b1;
            o_idx   = w_pos[TW-1:0];
         end
      end
   end

endmodule

// File: rtl/vpifo_pop_sched.sv
// Weighted round-robin pop scheduler for one level port of the multi-tree
// SRAM PIFO. Tracks per-tree occupancy from observed pushes, issues pops
// with their tree id, and realigns returned pop data with that tree id.
// Optional macro VPIFO_SCHED_STATS_EN adds per-tree pop/drop statistics.
// Ports:
//   i_clk, i_rst            - clock, synchronous active-high reset
//   i_enable                - scheduler may issue pops
//   i_cfg_we/tree/weight    - per-tree weight write (0 disables the tree)
//   i_push, i_push_tree_id  - push observed toward the PIFO
//   o_push_ready            - addressed tree below capacity (combinational)
//   o_push_drop             - a push was refused in the previous cycle
//   i_fifo_full             - PIFO task FIFO full, stalls issue
//   o_pop, o_pop_tree_id    - registered pop request
//   i_pop_data              - PIFO data, valid POP_LAT cycles after o_pop
//   o_deq_valid/tree_id/data- realigned dequeued element
//   o_nonempty              - per-tree occupancy non-zero
//   i_stat_tree, o_stat_count (stats build only) - {drops, pops} readout
//
// state | meaning
// IDLE  | pick next eligible tree from rr pointer, load its credit
// SERVE | issue pops for cur while credit and count remain
module vpifo_pop_sched
   import vpifo_sched_pkg::*;
#(
   parameter int PTW      = 16,
   parameter int LEVEL    = 4,
   parameter int TREE_NUM = 4,
   parameter int WW       = 4,
   parameter int POP_LAT  = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_enable,
   input  logic                        i_cfg_we,
   input  logic [$clog2(TREE_NUM)-1:0] i_cfg_tree,
   input  logic [WW-1:0]               i_cfg_weight,
   input  logic                        i_push,
   input  logic [$clog2(TREE_NUM)-1:0] i_push_tree_id,
   output logic                        o_push_ready,
   output logic                        o_push_drop,
   input  logic                        i_fifo_full,
   output logic                        o_pop,
   output logic [$clog2(TREE_NUM)-1:0] o_pop_tree_id,
   input  logic [PTW-1:0]              i_pop_data,
   output logic                        o_deq_valid,
   output logic [$clog2(TREE_NUM)-1:0] o_deq_tree_id,
   output logic [PTW-1:0]              o_deq_data,
`ifdef VPIFO_SCHED_STATS_EN
   input  logic [$clog2(TREE_NUM)-1:0] i_stat_tree,
   output logic [31:0]                 o_stat_count,
`endif
   output logic [TREE_NUM-1:0]         o_nonempty
);

   localparam int TW    = $clog2(TREE_NUM);
   localparam int CAP_V = cap(LEVEL);
   localparam int CW    = $clog2(CAP_V + 1);
   localparam logic [CW-1:0] CAP_C = CW'(CAP_V);

   logic [CW-1:0]  r_count  [TREE_NUM];
   logic [WW-1:0]  r_weight [TREE_NUM];
   state_t         r_state;
   logic [TW-1:0]  r_cur;
   logic [TW-1:0]  r_rr;
   logic [WW-1:0]  r_credit;

   logic [TREE_NUM-1:0] w_elig;
   logic                w_pick_found;
   logic [TW-1:0]       w_pick_idx;
   logic                w_push_ok;
   logic                w_issue;
   logic                w_cur_push;
   logic [CW-1:0]       w_cur_cnt_nxt;
   logic                w_exit;

   assign o_push_ready  = r_count[i_push_tree_id] < CAP_C;
   assign w_push_ok     = i_push && o_push_ready;
   assign w_issue       = (r_state == SERVE) && i_enable && !i_fifo_full &&
                          (r_count[r_cur] != '0) && (r_credit != '0);
   assign w_cur_push    = w_push_ok && (i_push_tree_id == r_cur);
   // Count of cur after this cycle's pop and any same-tree push.
   assign w_cur_cnt_nxt = r_count[r_cur] - CW'(1) + {{(CW-1){1'b0}}, w_cur_push};
   assign w_exit        = w_issue && ((r_credit == WW'(1)) || (w_cur_cnt_nxt == '0));

   always_comb begin
      w_elig     = '0;
      o_nonempty = '0;
      for (int t = 0; t < TREE_NUM; t++) begin
         o_nonempty[t] = r_count[t] != '0;
         w_elig[t]     = (r_count[t] != '0) && (r_weight[t] != '0);
      end
   end

   vpifo_rr_pick #(.N(TREE_NUM), .TW(TW)) u_pick (
      .i_mask  (w_elig),
      .i_ptr   (r_rr),
      .o_found (w_pick_found),
      .o_idx   (w_pick_idx)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_push_drop <= 1'b0;
         for (int t = 0; t < TREE_NUM; t++) begin
            r_count[t]  <= '0;
            r_weight[t] <= WW'(1);
         end
      end else begin
         o_push_drop <= i_push && !w_push_ok;
         for (int t = 0; t < TREE_NUM; t++) begin
            if (i_cfg_we && (i_cfg_tree == TW'(t))) r_weight[t] <= i_cfg_weight;
            if (w_push_ok && (i_push_tree_id == TW'(t)) && !(w_issue && (r_cur == TW'(t))))
               r_count[t] <= r_count[t] + CW'(1);
            else if (!(w_push_ok && (i_push_tree_id == TW'(t))) && w_issue && (r_cur == TW'(t)))
               r_count[t] <= r_count[t] - CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_cur         <= '0;
         r_rr          <= '0;
         r_credit      <= '0;
         o_pop         <= 1'b0;
         o_pop_tree_id <= '0;
      end else begin
         o_pop         <= w_issue;
         o_pop_tree_id <= w_issue ? r_cur : '0;
         case (r_state)
            IDLE: begin
               if (i_enable && w_pick_found) begin
                  r_cur    <= w_pick_idx;
                  r_credit <= r_weight[w_pick_idx];
                  r_state  <= SERVE;
               end
            end
            SERVE: begin
               if (w_issue) begin
                  r_credit <= r_credit - WW'(1);
                  if (w_exit) begin
                     r_state <= IDLE;
                     r_rr    <= (r_cur == TW'(TREE_NUM-1)) ? '0 : r_cur + TW'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Return path: stage k holds o_pop delayed by k cycles; data is
   // captured when stage POP_LAT lines up with i_pop_data.
   logic [POP_LAT:1] r_sh_vld;
   logic [TW-1:0]    r_sh_tid [1:POP_LAT];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sh_vld      <= '0;
         for (int k = 1; k <= POP_LAT; k++) r_sh_tid[k] <= '0;
         o_deq_valid   <= 1'b0;
         o_deq_tree_id <= '0;
         o_deq_data    <= '0;
      end else begin
         r_sh_vld[1] <= o_pop;
         r_sh_tid[1] <= o_pop_tree_id;
         for (int k = 2; k <= POP_LAT; k++) begin
            r_sh_vld[k] <= r_sh_vld[k-1];
            r_sh_tid[k] <= r_sh_tid[k-1];
         end
         o_deq_valid   <= r_sh_vld[POP_LAT];
         o_deq_tree_id <= r_sh_vld[POP_LAT] ? r_sh_tid[POP_LAT] : '0;
         o_deq_data    <= r_sh_vld[POP_LAT] ? i_pop_data : '0;
      end
   end

`ifdef VPIFO_SCHED_STATS_EN
   logic [15:0] r_stat_pops  [TREE_NUM];
   logic [15:0] r_stat_drops [TREE_NUM];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int t = 0; t < TREE_NUM; t++) begin
            r_stat_pops[t]  <= '0;
            r_stat_drops[t] <= '0;
         end
         o_stat_count <= '0;
      end else begin
         for (int t = 0; t < TREE_NUM; t++) begin
            if (w_issue && (r_cur == TW'(t)) && (r_stat_pops[t] != 16'hFFFF))
               r_stat_pops[t] <= r_stat_pops[t] + 16'd1;
            if (i_push && !w_push_ok && (i_push_tree_id == TW'(t)) && (r_stat_drops[t] != 16'hFFFF))
               r_stat_drops[t] <= r_stat_drops[t] + 16'd1;
         end
         o_stat_count <= {r_stat_drops[i_stat_tree], r_stat_pops[i_stat_tree]};
      end
   end
`endif

endmodule

// File: tb/tb_vpifo_pop_sched.sv
// Directed bench for vpifo_pop_sched: WRR order, capacity, same-cycle
// push/pop, backpressure, disabled trees and reset mid-flight.
module tb_vpifo_pop_sched;
   import vpifo_sched_pkg::*;

   localparam int PTW      = 16;
   localparam int LEVEL    = 4;
   localparam int TREE_NUM = 4;
   localparam int WW       = 4;
   localparam int POP_LAT  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst, en, cfg_we, push, fifo_full;
   logic [TID_W-1:0]   cfg_tree, push_id;
   logic [WW-1:0]      cfg_w;
   wire                push_ready, push_drop, pop, deq_v;
   wire  [TID_W-1:0]   pop_tid, deq_tid;
   wire  [PTW-1:0]     pop_data, deq_data;
   wire  [TREE_NUM-1:0] nonempty;
`ifdef VPIFO_SCHED_STATS_EN
   logic [TID_W-1:0]   stat_tree;
   wire  [31:0]        stat_count;
`endif

   vpifo_pop_sched #(.PTW(PTW), .LEVEL(LEVEL), .TREE_NUM(TREE_NUM), .WW(WW), .POP_LAT(POP_LAT)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_enable       (en),
      .i_cfg_we       (cfg_we),
      .i_cfg_tree     (cfg_tree),
      .i_cfg_weight   (cfg_w),
      .i_push         (push),
      .i_push_tree_id (push_id),
      .o_push_ready   (push_ready),
      .o_push_drop    (push_drop),
      .i_fifo_full    (fifo_full),
      .o_pop          (pop),
      .o_pop_tree_id  (pop_tid),
      .i_pop_data     (pop_data),
      .o_deq_valid    (deq_v),
      .o_deq_tree_id  (deq_tid),
      .o_deq_data     (deq_data),
`ifdef VPIFO_SCHED_STATS_EN
      .i_stat_tree    (stat_tree),
      .o_stat_count   (stat_count),
`endif
      .o_nonempty     (nonempty)
   );

   // PIFO model: k-th pop of tree t returns t*256+k after POP_LAT cycles.
   int               cyc = 0;
   int               pop_seq [TREE_NUM];
   logic [PTW-1:0]   pd1 = '0, pd2 = '0;
   logic [TID_W-1:0] pop_tid_q [$];
   int               pop_cyc_q [$];
   logic [TID_W-1:0] deq_tid_q [$];
   logic [PTW-1:0]   deq_dat_q [$];
   int               deq_cyc_q [$];

   assign pop_data = pd2;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         pop_tid_q.delete();
         pop_cyc_q.delete();
         deq_tid_q.delete();
         deq_dat_q.delete();
         deq_cyc_q.delete();
         for (int t = 0; t < TREE_NUM; t++) pop_seq[t] <= 0;
         pd1 <= '0;
         pd2 <= '0;
      end else begin
         if (pop) begin
            pop_tid_q.push_back(pop_tid);
            pop_cyc_q.push_back(cyc);
            pd1 <= PTW'(int'(pop_tid) * 256 + pop_seq[pop_tid]);
            pop_seq[pop_tid] <= pop_seq[pop_tid] + 1;
         end else begin
            pd1 <= 16'hDEAD;
         end
         pd2 <= pd1;
         if (deq_v) begin
            deq_tid_q.push_back(deq_tid);
            deq_dat_q.push_back(deq_data);
            deq_cyc_q.push_back(cyc);
         end
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ptid(input int i);
      return (i < pop_tid_q.size()) ? 32'(pop_tid_q[i]) : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] pcyc(input int i);
      return (i < pop_cyc_q.size()) ? 32'(pop_cyc_q[i]) : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] dtid(input int i);
      return (i < deq_tid_q.size()) ? 32'(deq_tid_q[i]) : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] ddat(input int i);
      return (i < deq_dat_q.size()) ? 32'(deq_dat_q[i]) : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] dcyc(input int i);
      return (i < deq_cyc_q.size()) ? 32'(deq_cyc_q[i]) : 32'hFFFF_FFFF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; cfg_we = 1'b0; push = 1'b0; fifo_full = 1'b0;
      cfg_tree = '0; cfg_w = '0; push_id = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_w(input int t, input int w);
      cfg_we = 1'b1; cfg_tree = TID_W'(t); cfg_w = WW'(w);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic push_n(input int t, input int n);
      for (int i = 0; i < n; i++) begin
         push = 1'b1; push_id = TID_W'(t);
         tick();
      end
      push = 1'b0;
   endtask

   int exp1 [20] = '{0,0,1,2,3, 0,0,1,2,3, 0,1,2,3, 1,2,3, 1,2,3};

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int seen [TREE_NUM];
      bit found;
`ifdef VPIFO_SCHED_STATS_EN
      stat_tree = '0;
`endif
      // Reset state
      do_reset();
      check_eq("rst_pop",      32'(pop),        0);
      check_eq("rst_pop_tid",  32'(pop_tid),    0);
      check_eq("rst_deq_v",    32'(deq_v),      0);
      check_eq("rst_deq_data", 32'(deq_data),   0);
      check_eq("rst_drop",     32'(push_drop),  0);
      check_eq("rst_nonempty", 32'(nonempty),   0);
      check_eq("rst_ready",    32'(push_ready), 1);

      // Basic WRR, weights {2,1,1,1}, 5 pushes per tree
      set_w(0, 2);
      for (int t = 0; t < TREE_NUM; t++) push_n(t, 5);
      check_eq("wrr_nonempty", 32'(nonempty), 32'hF);
      en = 1'b1;
      repeat (70) tick();
      en = 1'b0;
      check_eq("wrr_npop", 32'(pop_tid_q.size()), 20);
      check_eq("wrr_ndeq", 32'(deq_tid_q.size()), 20);
      for (int t = 0; t < TREE_NUM; t++) seen[t] = 0;
      for (int i = 0; i < 20; i++) begin
         check_eq($sformatf("wrr_tid%0d", i),  ptid(i), 32'(exp1[i]));
         check_eq($sformatf("wrr_dtid%0d", i), dtid(i), 32'(exp1[i]));
         check_eq($sformatf("wrr_data%0d", i), ddat(i), 32'(exp1[i] * 256 + seen[exp1[i]]));
         check_eq($sformatf("wrr_lat%0d", i),  dcyc(i) - pcyc(i), 32'(POP_LAT + 1));
         seen[exp1[i]]++;
      end
      check_eq("wrr_gap_burst",  pcyc(1) - pcyc(0), 1);
      check_eq("wrr_gap_bubble", pcyc(2) - pcyc(1), 2);
      check_eq("wrr_empty",      32'(nonempty), 0);

      // Capacity on tree 2
      do_reset();
      push_n(2, 339);
      push_id = 2'd2;
      check_eq("cap_ready339", 32'(push_ready), 1);
      push_n(2, 1);
      push_id = 2'd2;
      check_eq("cap_ready340", 32'(push_ready), 0);
      check_eq("cap_nodrop",   32'(push_drop),  0);
      push_n(2, 1);
      check_eq("cap_drop",     32'(push_drop),  1);
      check_eq("cap_nonempty", 32'(nonempty),   32'h4);
      tick();
      check_eq("cap_drop_end", 32'(push_drop),  0);
      push_id = 2'd1;
      check_eq("cap_ready_t1", 32'(push_ready), 1);
`ifdef VPIFO_SCHED_STATS_EN
      stat_tree = 2'd2;
      tick();
      check_eq("cap_stat", stat_count, 32'h0001_0000);
`endif

      // Same-tree push and pop in one cycle, then rr pointer check
      do_reset();
      set_w(1, 4);
      push_n(1, 1);
      en = 1'b1;
      tick();
      push = 1'b1; push_id = 2'd1;
      tick();
      push = 1'b0;
      check_eq("sim_pop1",     32'(pop),      1);
      check_eq("sim_tid1",     32'(pop_tid),  1);
      check_eq("sim_cnt_kept", 32'(nonempty), 32'h2);
      tick();
      check_eq("sim_pop2",     32'(pop),      1);
      check_eq("sim_drained",  32'(nonempty), 0);
      tick();
      check_eq("sim_idle",     32'(pop),      0);
      en = 1'b0;
      push_n(0, 1);
      push_n(2, 1);
      en = 1'b1;
      repeat (12) tick();
      en = 1'b0;
      check_eq("sim_npop", 32'(pop_tid_q.size()), 4);
      check_eq("sim_t0", ptid(0), 1);
      check_eq("sim_t1", ptid(1), 1);
      check_eq("sim_rr", ptid(2), 2);
      check_eq("sim_t3", ptid(3), 0);
      check_eq("sim_d0", ddat(0), 32'h100);
      check_eq("sim_d1", ddat(1), 32'h101);
      check_eq("sim_d2", ddat(2), 32'h200);
      check_eq("sim_d3", ddat(3), 32'h000);

      // Backpressure mid-burst
      do_reset();
      set_w(0, 4);
      push_n(0, 6);
      en = 1'b1;
      tick();
      tick();
      fifo_full = 1'b1;
      check_eq("bp_first", 32'(pop), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq($sformatf("bp_nopop%0d", i), 32'(pop), 0);
      end
      check_eq("bp_nonempty", 32'(nonempty), 32'h1);
      fifo_full = 1'b0;
      repeat (15) tick();
      en = 1'b0;
      check_eq("bp_npop", 32'(pop_tid_q.size()), 6);
      for (int i = 0; i < 6; i++) check_eq($sformatf("bp_tid%0d", i), ptid(i), 0);
      check_eq("bp_gap_stall", pcyc(1) - pcyc(0), 6);
      check_eq("bp_gap_a",     pcyc(2) - pcyc(1), 1);
      check_eq("bp_gap_b",     pcyc(3) - pcyc(2), 1);
      check_eq("bp_gap_burst", pcyc(4) - pcyc(3), 2);
      check_eq("bp_gap_c",     pcyc(5) - pcyc(4), 1);

      // Disabled tree and empty idle
      do_reset();
      set_w(3, 0);
      push_n(3, 10);
      push_n(1, 2);
      en = 1'b1;
      repeat (30) tick();
      check_eq("dis_npop",     32'(pop_tid_q.size()), 2);
      check_eq("dis_t0",       ptid(0), 1);
      check_eq("dis_t1",       ptid(1), 1);
      check_eq("dis_nonempty", 32'(nonempty), 32'h8);
      check_eq("dis_idle_pop", 32'(pop), 0);
      en = 1'b0;

      // Reset one cycle after o_pop
      do_reset();
      push_n(0, 3);
      en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (pop) found = 1'b1;
      end
      check_eq("rmf_seen_pop", 32'(found), 1);
      tick();
      rst = 1'b1; en = 1'b0;
      tick();
      rst = 1'b0;
      repeat (8) tick();
      check_eq("rmf_ndeq",     32'(deq_tid_q.size()), 0);
      check_eq("rmf_deq_v",    32'(deq_v),    0);
      check_eq("rmf_pop",      32'(pop),      0);
      check_eq("rmf_nonempty", 32'(nonempty), 0);
`ifdef VPIFO_SCHED_STATS_EN
      check_eq("rmf_stat",     stat_count,    0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
